// File: rtl/mipi_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mipi_frame_scheduler: continuous/single/burst frame launch sequencer with
// inter-frame gap, hung-frame watchdog and frame/error statistics. Rev 1.0
// ---------------------------------------------------------------------------
module mipi_frame_scheduler #(
    parameter int PERIOD_W       = 32,
    parameter int CNT_W          = 16,
    parameter int MIN_GAP        = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] frame_period,
    input  logic [CNT_W-1:0]    burst_count,
    input  logic                start_req,
    input  logic                err_clr,
    output logic                frame_start,
    input  logic                frame_active,
    input  logic                frame_done,
    output logic                busy,
    output logic                burst_done,
    output logic [CNT_W-1:0]    frames_sent,
    output logic                timeout_err,
    output logic [7:0]          timeout_cnt
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LAUNCH      = 3'd1;
    localparam logic [2:0] S_WAIT_DONE   = 3'd2;
    localparam logic [2:0] S_GAP         = 3'd3;
    localparam logic [2:0] S_WAIT_PERIOD = 3'd4;

    localparam logic [1:0] M_CONT   = 2'd0;
    localparam logic [1:0] M_SINGLE = 2'd1;
    localparam logic [1:0] M_BURST  = 2'd2;

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]          state_q, state_d;
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [CNT_W-1:0]    remain_q;
    logic [WD_W-1:0]     wd_q;
    logic [GAP_W-1:0]    gap_q;
    logic                frame_start_q, frame_start_d;
    logic                burst_done_q, burst_done_d;
    logic [CNT_W-1:0]    frames_sent_q;
    logic                timeout_err_q;
    logic [7:0]          timeout_cnt_q;

    logic [1:0]          mode_in;
    logic                launch_idle;
    logic                burst_zero;
    logic                done_evt;
    logic                timeout_evt;
    logic                gap_end;
    logic                seq_end;
    logic                relatch;
    logic [PERIOD_W-1:0] period_src;

    // frame_active is observed by the host only; nothing here depends on it
    logic unused_frame_active;
    assign unused_frame_active = frame_active;

    assign mode_in     = (mode == 2'd3) ? M_SINGLE : mode;
    assign launch_idle = enable && ((mode_in == M_CONT) ||
                         (start_req && ((mode_in == M_SINGLE) ||
                                        (mode_in == M_BURST && burst_count != '0))));
    assign burst_zero  = (state_q == S_IDLE) && enable && start_req &&
                         (mode_in == M_BURST) && (burst_count == '0);
    assign done_evt    = (state_q == S_WAIT_DONE) && frame_done;
    assign timeout_evt = (state_q == S_WAIT_DONE) && !frame_done &&
                         (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign gap_end     = (state_q == S_GAP) && (gap_q == GAP_W'(MIN_GAP - 1));
    assign seq_end     = (mode_q == M_SINGLE) ||
                         (mode_q == M_BURST && remain_q == '0) || !enable;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (launch_idle) state_d = S_LAUNCH;
            S_LAUNCH:      state_d = S_WAIT_DONE;
            S_WAIT_DONE:   if (done_evt || timeout_evt) state_d = S_GAP;
            S_GAP:         if (gap_end) state_d = seq_end ? S_IDLE : S_WAIT_PERIOD;
            S_WAIT_PERIOD: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (period_cnt_q == '0) begin
                    state_d = S_LAUNCH;
                end
            end
            default:       state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        frame_start_d = (state_d == S_LAUNCH);
        burst_done_d  = burst_zero || (gap_end && seq_end && mode_q != M_CONT);
        busy          = (state_q != S_IDLE);
    end

    // Settings are taken on leaving IDLE and again on every continuous-mode launch
    assign relatch    = (state_d == S_LAUNCH) && ((state_q == S_IDLE) || (mode_q == M_CONT));
    assign period_src = relatch ? frame_period : period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= M_CONT;
            period_q      <= '0;
            remain_q      <= '0;
            period_cnt_q  <= '0;
            wd_q          <= '0;
            gap_q         <= '0;
            frame_start_q <= 1'b0;
            burst_done_q  <= 1'b0;
            frames_sent_q <= '0;
            timeout_err_q <= 1'b0;
            timeout_cnt_q <= 8'd0;
        end else begin
            frame_start_q <= frame_start_d;
            burst_done_q  <= burst_done_d;

            if (relatch) begin
                mode_q   <= mode_in;
                period_q <= frame_period;
                remain_q <= burst_count;
            end else if (state_q == S_LAUNCH && mode_q == M_BURST && remain_q != '0) begin
                remain_q <= remain_q - CNT_W'(1);
            end

            if (state_d == S_LAUNCH) begin
                period_cnt_q <= (period_src == '0) ? '0 : period_src - PERIOD_W'(1);
            end else if (state_q != S_IDLE && period_cnt_q != '0) begin
                period_cnt_q <= period_cnt_q - PERIOD_W'(1);
            end

            wd_q  <= (state_q == S_WAIT_DONE) ? wd_q + WD_W'(1) : '0;
            gap_q <= (state_q == S_GAP) ? gap_q + GAP_W'(1) : '0;

            if (done_evt) begin
                frames_sent_q <= frames_sent_q + CNT_W'(1);
            end

            // A clear wins over a same-cycle timeout for the flag; the count restarts at it
            if (err_clr) begin
                timeout_err_q <= 1'b0;
                timeout_cnt_q <= timeout_evt ? 8'd1 : 8'd0;
            end else if (timeout_evt) begin
                timeout_err_q <= 1'b1;
                if (timeout_cnt_q != 8'hFF) begin
                    timeout_cnt_q <= timeout_cnt_q + 8'd1;
                end
            end
        end
    end

    assign frame_start = frame_start_q;
    assign burst_done  = burst_done_q;
    assign frames_sent = frames_sent_q;
    assign timeout_err = timeout_err_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mipi_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mipi_frame_scheduler: scoreboard bench for the frame scheduler. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mipi_frame_scheduler;

    localparam int PERIOD_W = 32;
    localparam int CNT_W    = 16;
    localparam int MIN_GAP  = 16;
    localparam int TMO      = 5000;

    localparam int SIG_BUSY = 0;
    localparam int SIG_FS   = 1;
    localparam int SIG_TERR = 2;
    localparam int SIG_TCNT = 3;
    localparam int SIG_FST  = 4;
    localparam int SIG_BD   = 5;

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] frame_period;
    logic [CNT_W-1:0]    burst_count;
    logic                start_req;
    logic                err_clr;
    logic                frame_start;
    logic                frame_active;
    logic                frame_done;
    logic                busy;
    logic                burst_done;
    logic [CNT_W-1:0]    frames_sent;
    logic                timeout_err;
    logic [7:0]          timeout_cnt;

    logic gen_done;
    logic gen_busy;
    logic man_done;
    logic gen_stall;
    int   gen_len;
    int   cyc = 0;
    logic fin;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } lvl_t;

    int   exp_start[$];
    int   exp_bd[$];
    lvl_t lvl_q[$];
    lvl_t keep_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_c;
    int   act;

    mipi_frame_scheduler #(
        .PERIOD_W       (PERIOD_W),
        .CNT_W          (CNT_W),
        .MIN_GAP        (MIN_GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .frame_period (frame_period),
        .burst_count  (burst_count),
        .start_req    (start_req),
        .err_clr      (err_clr),
        .frame_start  (frame_start),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .busy         (busy),
        .burst_done   (burst_done),
        .frames_sent  (frames_sent),
        .timeout_err  (timeout_err),
        .timeout_cnt  (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign frame_done   = gen_done | man_done;
    assign frame_active = gen_busy;

    // Packet generator model: frame_done arrives gen_len cycles after frame_start
    initial begin
        gen_done = 1'b0;
        gen_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_start && !gen_stall) begin
                gen_busy = 1'b1;
                repeat (gen_len) @(negedge clk);
                gen_done = 1'b1;
                @(negedge clk);
                gen_done = 1'b0;
                gen_busy = 1'b0;
            end
        end
    end

    function automatic int sig_val(input int s);
        case (s)
            SIG_BUSY: return int'(busy);
            SIG_FS:   return int'(frames_sent);
            SIG_TERR: return int'(timeout_err);
            SIG_TCNT: return int'(timeout_cnt);
            SIG_FST:  return int'(frame_start);
            default:  return int'(burst_done);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            SIG_BUSY: return "busy";
            SIG_FS:   return "frames_sent";
            SIG_TERR: return "timeout_err";
            SIG_TCNT: return "timeout_cnt";
            SIG_FST:  return "frame_start";
            default:  return "burst_done";
        endcase
    endfunction

    // Monitor: pulses are matched against queued cycle stamps, levels against queued values
    always @(negedge clk) begin
        if (frame_start) begin
            checks++;
            if (exp_start.size() == 0) begin
                errors++;
                $display("FAIL frame_start: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_c = exp_start.pop_front();
                if (exp_c != cyc) begin
                    errors++;
                    $display("FAIL frame_start: got cycle %0d, expected cycle %0d", cyc, exp_c);
                end
            end
        end
        if (burst_done) begin
            checks++;
            if (exp_bd.size() == 0) begin
                errors++;
                $display("FAIL burst_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_c = exp_bd.pop_front();
                if (exp_c != cyc) begin
                    errors++;
                    $display("FAIL burst_done: got cycle %0d, expected cycle %0d", cyc, exp_c);
                end
            end
        end
        keep_q.delete();
        foreach (lvl_q[i]) begin
            if (lvl_q[i].cyc == cyc) begin
                checks++;
                act = sig_val(lvl_q[i].sig);
                if (act != lvl_q[i].val) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                             sig_name(lvl_q[i].sig), cyc, act, lvl_q[i].val);
                end
            end else begin
                keep_q.push_back(lvl_q[i]);
            end
        end
        lvl_q = keep_q;
        if (fin) begin
            checks++;
            if (exp_start.size() != 0) begin
                errors++;
                $display("FAIL missing frame_start: got %0d leftover, expected 0", exp_start.size());
            end
            checks++;
            if (exp_bd.size() != 0) begin
                errors++;
                $display("FAIL missing burst_done: got %0d leftover, expected 0", exp_bd.size());
            end
            checks++;
            if (lvl_q.size() != 0) begin
                errors++;
                $display("FAIL unchecked levels: got %0d leftover, expected 0", lvl_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic exp_lvl(input int c, input int s, input int v);
        lvl_t x;
        x.cyc = c;
        x.sig = s;
        x.val = v;
        lvl_q.push_back(x);
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
    endtask

    int e;
    int t;
    int c;

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; frame_period = '0; burst_count = '0;
        start_req = 1'b0; err_clr = 1'b0; man_done = 1'b0; gen_stall = 1'b0;
        gen_len = 10; fin = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            exp_lvl(k, SIG_BUSY, 0); exp_lvl(k, SIG_FS, 0); exp_lvl(k, SIG_TERR, 0);
            exp_lvl(k, SIG_TCNT, 0); exp_lvl(k, SIG_FST, 0); exp_lvl(k, SIG_BD, 0);
        end
        at_cycle(3);
        rst_n = 1'b1;

        // Continuous, period 2000, 1200-cycle frames; enable dropped mid third frame
        at_cycle(10);
        e = cyc;
        mode = 2'd0; frame_period = 2000; gen_len = 1200; enable = 1'b1;
        exp_start.push_back(e + 1);
        exp_start.push_back(e + 2001);
        exp_start.push_back(e + 4001);
        exp_lvl(e + 1300, SIG_FS, 1);
        exp_lvl(e + 5217, SIG_BUSY, 1);   // last GAP cycle: done e+5201, GAP e+5202..e+5217
        exp_lvl(e + 5218, SIG_BUSY, 0);
        exp_lvl(e + 5218, SIG_FS, 3);
        at_cycle(e + 4101);
        enable = 1'b0;

        // Gap-limited: period 0, 50-cycle frames -> start = done + 18
        at_cycle(e + 5240);
        e = cyc;
        frame_period = 0; gen_len = 50; enable = 1'b1;
        exp_start.push_back(e + 1);
        exp_start.push_back(e + 69);
        exp_start.push_back(e + 137);
        exp_lvl(e + 203, SIG_BUSY, 1);
        exp_lvl(e + 204, SIG_BUSY, 0);
        exp_lvl(e + 204, SIG_FS, 6);
        at_cycle(e + 140);
        enable = 1'b0;

        // Burst of 3, period 100, 40-cycle frames; stray start_req mid-burst
        at_cycle(e + 220);
        e = cyc;
        mode = 2'd2; burst_count = 3; frame_period = 100; gen_len = 40; enable = 1'b1;
        exp_start.push_back(e + 1);
        exp_start.push_back(e + 101);
        exp_start.push_back(e + 201);
        exp_bd.push_back(e + 258);        // third done e+241, GAP ends e+257
        exp_lvl(e + 50, SIG_BUSY, 1);
        exp_lvl(e + 257, SIG_BUSY, 1);
        exp_lvl(e + 258, SIG_BUSY, 0);
        exp_lvl(e + 258, SIG_FS, 9);
        pulse_start();
        at_cycle(e + 150);
        pulse_start();

        // Burst of 0: immediate burst_done, no launch
        at_cycle(e + 270);
        e = cyc;
        burst_count = 0;
        exp_bd.push_back(e + 1);
        exp_lvl(e + 1, SIG_BUSY, 0);
        exp_lvl(e + 2, SIG_BUSY, 0);
        pulse_start();

        // start_req while disabled is ignored
        at_cycle(e + 10);
        e = cyc;
        enable = 1'b0; mode = 2'd1;
        exp_lvl(e + 2, SIG_BUSY, 0);
        pulse_start();

        // Reserved mode 3 behaves as single
        at_cycle(e + 10);
        e = cyc;
        enable = 1'b1; mode = 2'd3; gen_len = 40;
        exp_start.push_back(e + 1);
        exp_bd.push_back(e + 58);
        exp_lvl(e + 57, SIG_BUSY, 1);
        exp_lvl(e + 58, SIG_FS, 10);
        pulse_start();

        // Timeout on a stalled generator, then err_clr
        at_cycle(e + 70);
        e = cyc;
        t = e + 1;
        mode = 2'd1; gen_stall = 1'b1;
        exp_start.push_back(t);
        exp_lvl(t + TMO, SIG_TERR, 0);
        exp_lvl(t + TMO + 1, SIG_TERR, 1);
        exp_lvl(t + TMO + 1, SIG_TCNT, 1);
        exp_lvl(t + TMO + 1, SIG_BUSY, 1);
        exp_bd.push_back(t + TMO + 17);
        exp_lvl(t + TMO + 17, SIG_FS, 10);
        exp_lvl(t + TMO + 25, SIG_TERR, 1);
        exp_lvl(t + TMO + 25, SIG_TCNT, 1);
        pulse_start();
        at_cycle(t + TMO + 30);
        c = cyc;
        exp_lvl(c + 1, SIG_TERR, 0);
        exp_lvl(c + 1, SIG_TCNT, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Second timeout with err_clr in the expiry cycle
        at_cycle(c + 10);
        e = cyc;
        t = e + 1;
        exp_start.push_back(t);
        exp_lvl(t + TMO + 1, SIG_TERR, 0);
        exp_lvl(t + TMO + 1, SIG_TCNT, 1);
        exp_bd.push_back(t + TMO + 17);
        pulse_start();
        at_cycle(t + TMO);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Asynchronous reset while waiting for frame_done
        at_cycle(t + TMO + 30);
        e = cyc;
        mode = 2'd0; enable = 1'b1;
        exp_start.push_back(e + 1);
        exp_lvl(e + 10, SIG_BUSY, 1);
        exp_lvl(e + 10, SIG_FS, 10);
        exp_lvl(e + 10, SIG_TCNT, 1);
        at_cycle(e + 20);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        c = cyc;
        exp_lvl(c, SIG_BUSY, 0);
        exp_lvl(c, SIG_FS, 0);
        exp_lvl(c, SIG_TCNT, 0);
        exp_lvl(c, SIG_TERR, 0);
        exp_lvl(c, SIG_FST, 0);
        at_cycle(e + 25);
        rst_n = 1'b1;
        exp_lvl(e + 32, SIG_FS, 0);
        exp_lvl(e + 32, SIG_BUSY, 0);
        at_cycle(e + 28);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;

        at_cycle(e + 40);
        fin = 1'b1;
    end

endmodule
`default_nettype wire
